// File: rtl/demux_5bit_if.sv
// Handshake bundle for the registered 1-to-5 demultiplexer: one source side, five lanes out.
interface demux_5bit_if #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
);
  logic [WIDTH-1:0]     in_data;
  logic                 s0;
  logic                 s1;
  logic                 s2;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_data0;
  logic [WIDTH-1:0]     out_data1;
  logic [WIDTH-1:0]     out_data2;
  logic [WIDTH-1:0]     out_data3;
  logic [WIDTH-1:0]     out_data4;
  logic [4:0]           out_valid;
  logic [4:0]           out_ready;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_count;

  // Master is the operand source plus the lane consumers; slave is the demux itself.
  modport master (
    output in_data, s0, s1, s2, in_valid, out_ready,
    input  in_ready, out_data0, out_data1, out_data2, out_data3, out_data4,
           out_valid, err, err_count
  );

  modport slave (
    input  in_data, s0, s1, s2, in_valid, out_ready,
    output in_ready, out_data0, out_data1, out_data2, out_data3, out_data4,
           out_valid, err, err_count
  );
endinterface

// File: rtl/demux_5bit.sv
// Registered 1-to-5 demultiplexer with a one-entry valid/ready holding register per lane.
// Select code {s0,s1,s2} matches the result mux; codes 101..111 are dropped and counted.
module demux_5bit #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  demux_5bit_if.slave bus
);

  logic [2:0]           code;
  logic                 codeValid;
  logic [4:0]           selOneHot;
  logic [4:0]           laneFree;
  logic                 inReady;
  logic                 xfer;
  logic [4:0]           laneLoad;

  logic [WIDTH-1:0]     laneData [5];
  logic [4:0]           laneValid;
  logic                 errPulse;
  logic [ERR_CNT_W-1:0] errCount;

  assign code = {bus.s0, bus.s1, bus.s2};

  always_comb begin
    selOneHot = 5'b00000;
    codeValid = 1'b1;
    case (code)
      3'd0:    selOneHot = 5'b00001;
      3'd1:    selOneHot = 5'b00010;
      3'd2:    selOneHot = 5'b00100;
      3'd3:    selOneHot = 5'b01000;
      3'd4:    selOneHot = 5'b10000;
      default: codeValid = 1'b0;
    endcase
  end

  // A lane draining on this edge can accept a new word on the same edge.
  assign laneFree = ~laneValid | bus.out_ready;
  assign inReady  = codeValid ? |(selOneHot & laneFree) : 1'b1;
  assign xfer     = bus.in_valid && inReady;
  assign laneLoad = xfer ? selOneHot : 5'b00000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) begin
        laneData[k] <= '0;
      end
      laneValid <= 5'b00000;
      errPulse  <= 1'b0;
      errCount  <= '0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (laneLoad[k]) begin
          laneData[k]  <= bus.in_data;
          laneValid[k] <= 1'b1;
        end else if (bus.out_ready[k]) begin
          laneValid[k] <= 1'b0;
        end
      end
      errPulse <= xfer && !codeValid;
      if (xfer && !codeValid && (errCount != {ERR_CNT_W{1'b1}})) begin
        errCount <= errCount + 1'b1;
      end
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_data0 = laneData[0];
  assign bus.out_data1 = laneData[1];
  assign bus.out_data2 = laneData[2];
  assign bus.out_data3 = laneData[3];
  assign bus.out_data4 = laneData[4];
  assign bus.out_valid = laneValid;
  assign bus.err       = errPulse;
  assign bus.err_count = errCount;

endmodule

// File: tb/tb_demux_5bit.sv
// Directed bench for demux_5bit: vector table plus hand sequences for reset, throughput,
// lane independence and err_count saturation on a narrow-counter instance.
module tb_demux_5bit;

  logic clk;
  logic rst_n;

  demux_5bit_if #(.WIDTH(32), .ERR_CNT_W(8)) bus ();
  demux_5bit_if #(.WIDTH(32), .ERR_CNT_W(2)) bus2 ();

  demux_5bit #(.WIDTH(32), .ERR_CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  demux_5bit #(.WIDTH(32), .ERR_CNT_W(2)) dutSat (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  code;
    logic [31:0] data;
    logic        inValid;
    logic [4:0]  outReady;
    logic        expInReady;
    logic [4:0]  expValid;
    logic        expErr;
    logic [7:0]  expErrCnt;
    int          lane;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [14];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic [2:0] code, input logic [31:0] data,
                       input logic inValid, input logic [4:0] outReady);
    bus.s0        = code[2];
    bus.s1        = code[1];
    bus.s2        = code[0];
    bus.in_data   = data;
    bus.in_valid  = inValid;
    bus.out_ready = outReady;
  endtask

  function automatic logic [31:0] laneOut(input int k);
    case (k)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      3:       return bus.out_data3;
      default: return bus.out_data4;
    endcase
  endfunction

  initial begin
    //          code  data          v     rdy       inRdy vld       err   cnt   lane data
    vecs[0]  = '{3'd0, 32'h10,       1'b1, 5'b00000, 1'b1, 5'b00001, 1'b0, 8'd0, 0, 32'h10};
    vecs[1]  = '{3'd1, 32'h11,       1'b1, 5'b00000, 1'b1, 5'b00011, 1'b0, 8'd0, 1, 32'h11};
    vecs[2]  = '{3'd2, 32'h12,       1'b1, 5'b00000, 1'b1, 5'b00111, 1'b0, 8'd0, 2, 32'h12};
    vecs[3]  = '{3'd3, 32'h13,       1'b1, 5'b00000, 1'b1, 5'b01111, 1'b0, 8'd0, 3, 32'h13};
    vecs[4]  = '{3'd4, 32'h14,       1'b1, 5'b00000, 1'b1, 5'b11111, 1'b0, 8'd0, 4, 32'h14};
    vecs[5]  = '{3'd5, 32'h99,       1'b1, 5'b00000, 1'b1, 5'b11111, 1'b1, 8'd1, 0, 32'h10};
    vecs[6]  = '{3'd6, 32'h98,       1'b1, 5'b00000, 1'b1, 5'b11111, 1'b1, 8'd2, 1, 32'h11};
    vecs[7]  = '{3'd7, 32'h97,       1'b1, 5'b00000, 1'b1, 5'b11111, 1'b1, 8'd3, 4, 32'h14};
    vecs[8]  = '{3'd0, 32'h55,       1'b0, 5'b00000, 1'b0, 5'b11111, 1'b0, 8'd3, 0, 32'h10};
    vecs[9]  = '{3'd4, 32'h77,       1'b1, 5'b10000, 1'b1, 5'b11111, 1'b0, 8'd3, 4, 32'h77};
    vecs[10] = '{3'd0, 32'h66,       1'b1, 5'b10000, 1'b0, 5'b01111, 1'b0, 8'd3, 0, 32'h10};
    vecs[11] = '{3'd3, 32'hA5,       1'b1, 5'b00000, 1'b0, 5'b01111, 1'b0, 8'd3, 3, 32'h13};
    vecs[12] = '{3'd3, 32'hA5,       1'b1, 5'b01000, 1'b1, 5'b01111, 1'b0, 8'd3, 3, 32'hA5};
    vecs[13] = '{3'd2, 32'h0,        1'b0, 5'b11111, 1'b1, 5'b00000, 1'b0, 8'd3, 2, 32'h12};

    rst_n = 1'b0;
    setIn(3'd0, 32'h0, 1'b0, 5'b00000);
    bus2.s0 = 1'b0; bus2.s1 = 1'b0; bus2.s2 = 1'b0;
    bus2.in_data = 32'h0; bus2.in_valid = 1'b0; bus2.out_ready = 5'b00000;
    #1;
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_out_valid", {27'd0, bus.out_valid}, 32'd0);
    check("reset_err", {31'd0, bus.err}, 32'd0);
    check("reset_err_count", {24'd0, bus.err_count}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      setIn(vecs[i].code, vecs[i].data, vecs[i].inValid, vecs[i].outReady);
      #1;
      check($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].expInReady});
      tick();
      check($sformatf("vec%0d_out_valid", i), {27'd0, bus.out_valid}, {27'd0, vecs[i].expValid});
      check($sformatf("vec%0d_err", i), {31'd0, bus.err}, {31'd0, vecs[i].expErr});
      check($sformatf("vec%0d_err_count", i), {24'd0, bus.err_count}, {24'd0, vecs[i].expErrCnt});
      check($sformatf("vec%0d_lane%0d_data", i, vecs[i].lane), laneOut(vecs[i].lane), vecs[i].expData);
    end

    // Throughput: lane 1 accepts and drains a word every cycle.
    for (int i = 1; i <= 8; i++) begin
      setIn(3'd1, 32'(i), 1'b1, 5'b00010);
      #1;
      check($sformatf("thru%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
      tick();
      check($sformatf("thru%0d_data1", i), bus.out_data1, 32'(i));
      check($sformatf("thru%0d_valid1", i), {31'd0, bus.out_valid[1]}, 32'd1);
    end
    setIn(3'd1, 32'h0, 1'b0, 5'b00010);
    tick();
    check("thru_drained", {27'd0, bus.out_valid}, 32'd0);

    // Independence: lane 4 drains while a write to full lane 0 is held off.
    setIn(3'd0, 32'hA0, 1'b1, 5'b00000);
    tick();
    setIn(3'd4, 32'hA4, 1'b1, 5'b00000);
    tick();
    check("indep_both_full", {27'd0, bus.out_valid}, 32'h11);
    setIn(3'd0, 32'hB0, 1'b1, 5'b10000);
    #1;
    check("indep_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("indep_valid", {27'd0, bus.out_valid}, 32'h01);
    check("indep_data0", bus.out_data0, 32'hA0);
    setIn(3'd0, 32'h0, 1'b0, 5'b11111);
    tick();

    // Asynchronous reset mid-cycle with lane 2 full.
    setIn(3'd2, 32'hDEADBEEF, 1'b1, 5'b00000);
    tick();
    check("pre_reset_data2", bus.out_data2, 32'hDEADBEEF);
    setIn(3'd2, 32'h0, 1'b0, 5'b00000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {27'd0, bus.out_valid}, 32'd0);
    check("async_rst_data2", bus.out_data2, 32'd0);
    check("async_rst_err_count", {24'd0, bus.err_count}, 32'd0);
    check("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    #1;
    rst_n = 1'b1;
    tick();

    // Saturation with a 2-bit counter.
    for (int i = 1; i <= 5; i++) begin
      bus2.s0 = 1'b1; bus2.s1 = 1'(i % 2); bus2.s2 = 1'b1;
      bus2.in_data = 32'(i); bus2.in_valid = 1'b1;
      tick();
      check($sformatf("sat%0d_err", i), {31'd0, bus2.err}, 32'd1);
      check($sformatf("sat%0d_count", i), {30'd0, bus2.err_count}, (i < 3) ? 32'(i) : 32'd3);
    end
    bus2.in_valid = 1'b0;
    tick();
    check("sat_err_clear", {31'd0, bus2.err}, 32'd0);
    check("sat_valid", {27'd0, bus2.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
